gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
Parametrised global-history (gshare) conditional-branch predictor for the LC-3b pipeline; successor to the fixed 5-bit PC-indexed predictor inside hazard detection. IF looks up a prediction combinationally. The pipeline carries the index and history snapshot to WB, which updates the pattern table and repairs the speculative history on a mispredict. A built-in init walker sets every table entry to weakly-not-taken after reset.

Parameters:
ADDR_W, 16, PC width
IDX_BITS, 5, log2 of pattern-table entries
HIST_BITS, 5, global history length; must satisfy 1 <= HIST_BITS <= IDX_BITS
CTR_BITS, 2, saturating counter width; must be >= 1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
ready  out  1  high once the init walk is complete
lookup_valid  in  1  IF holds a conditional branch (opcode br, nzp != 000)
lookup_pc  in  ADDR_W  IF instruction address
pred_taken  out  1  prediction (combinational)
pred_idx  out  IDX_BITS  table index used; carried down the pipeline
pred_hist  out  HIST_BITS  GHR value used; carried down the pipeline
upd_valid  in  1  WB retires a conditional branch
upd_idx  in  IDX_BITS  pred_idx carried with the branch
upd_hist  in  HIST_BITS  pred_hist carried with the branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  actual outcome differs from the carried prediction
stat_lookups  out  32  lookup count (PRED_STATS_EN only)
stat_updates  out  32  update count (PRED_STATS_EN only)
stat_mispredicts  out  32  mispredict count (PRED_STATS_EN only)

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to INIT, walk pointer = 0, GHR = 0, all stat counters = 0.
  - ready = 0.
- INIT state:
  - Each cycle writes table[ptr] = 2^(CTR_BITS-1)-1 (weakly not-taken; 1 when CTR_BITS = 2), then ptr++.
  - After writing entry 2^IDX_BITS-1 the FSM goes to READY. The walk takes exactly 2^IDX_BITS cycles; ready rises on the following cycle.
  - While in INIT: pred_taken = 0, lookups and updates are ignored, GHR holds.
- READY state:
  - Stays in READY until reset.
  - rst_n asserted mid-operation restarts INIT from ptr 0.
- Index: idx = lookup_pc[IDX_BITS:1] XOR zero-extend(GHR). Bit 0 is excluded because addresses are word-aligned.
- Prediction outputs (combinational):
  - pred_taken = MSB of table[idx].
  - pred_idx = idx; pred_hist = GHR.
  - All three are valid whenever ready is high, regardless of lookup_valid.
- Speculative history:
  - On lookup_valid & ready, GHR <= {GHR[HIST_BITS-2:0], pred_taken}.
  - For HIST_BITS = 1, GHR <= pred_taken.
- Counter update: on upd_valid & ready, table[upd_idx] saturating-increments if upd_taken, else saturating-decrements.
  - Saturation limits: 0 and 2^CTR_BITS-1. No wrap.
- Recovery: on upd_valid & upd_mispredict & ready, GHR <= {upd_hist[HIST_BITS-2:0], upd_taken}.
  - Recovery has priority over a same-cycle lookup shift; that lookup's shift is discarded.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update counter. No bypass.
- The table is a register array with one read port and one read-modify-write port. No reset on the array itself; the init walker covers it.
- upd_mispredict without upd_valid is ignored.

Optional Feature:
Macro PRED_STATS_EN.
- Defined: three 32-bit wrapping counters.
  - stat_lookups increments on lookup_valid & ready.
  - stat_updates increments on upd_valid & ready.
  - stat_mispredicts increments on upd_valid & upd_mispredict & ready.
  - All clear on reset.
- Undefined: the ports remain and are tied to 0; no counter flops are generated.

Test Plan:
- Reset then idle, IDX_BITS=5 -> ready low for 32 cycles, high on cycle 33. Every lookup during INIT gives pred_taken = 0. Every lookup after INIT gives pred_taken = 0, and the entry reads 1.
- GHR=0, lookup_pc=0x0046 -> pred_idx = 0x03. Four updates at idx 3, taken -> counter 1→2→3→3 (saturates). The next lookup of 0x0046 with GHR=0 gives pred_taken = 1.
- Three consecutive lookups predicting 0,0,0, then WB update with upd_hist=0b00011, upd_taken=1, upd_mispredict=1 -> next pred_hist = 0b00111.
- Same-cycle lookup (pred_taken = 1) and mispredict update (upd_hist=0, upd_taken=0) -> GHR becomes 0; the lookup shift is dropped.
- rst_n pulsed low 10 cycles after INIT completes -> ready drops immediately (async), GHR = 0, full 32-cycle re-walk. Entries trained to 3 read back as 1.
- PRED_STATS_EN defined: 5 lookups, 3 updates, 1 mispredict -> stat outputs 5/3/1. Undefined -> all stat outputs 0.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// Gshare conditional-branch predictor: GHR-xor-PC indexed table of saturating counters,
// self-initialising walker, speculative history with WB repair. Optional stats: PRED_STATS_EN.
module gshare_branch_predictor #(
  parameter int ADDR_W    = 16,
  parameter int IDX_BITS  = 5,
  parameter int HIST_BITS = 5,  // 1 <= HIST_BITS <= IDX_BITS
  parameter int CTR_BITS  = 2   // >= 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic                 lookup_valid,
  input  logic [ADDR_W-1:0]    lookup_pc,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispredicts
);

  localparam int                  ENTRIES     = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [HIST_BITS-1:0] ghr_q;

  logic                 lookup_fire;
  logic                 upd_fire;
  logic                 recover;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [HIST_BITS-1:0] ghr_shift;
  logic [HIST_BITS-1:0] ghr_recover;

  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [CTR_BITS-1:0] wr_data;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [CTR_BITS-1:0] upd_ctr_next;

  // ---------------------------------------------------------------------------
  // Init walker FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_BITS'(ENTRIES - 1)) state_d = S_READY;
      end
      S_READY: state_d = S_READY;
      default: state_d = S_INIT;
    endcase
  end

  assign ready       = (state_q == S_READY);
  assign lookup_fire = lookup_valid & ready;
  assign upd_fire    = upd_valid & ready;
  assign recover     = upd_fire & upd_mispredict;

  // ---------------------------------------------------------------------------
  // Lookup (read port). PC bit 0 is always zero for word-aligned instructions.
  // ---------------------------------------------------------------------------
  assign lookup_idx = lookup_pc[IDX_BITS:1] ^ IDX_BITS'(ghr_q);
  assign pred_idx   = lookup_idx;
  assign pred_hist  = ghr_q;
  assign pred_taken = ready & table_q[lookup_idx][CTR_BITS-1];

  // ---------------------------------------------------------------------------
  // Read-modify-write port: shared by the init walker and WB training
  // ---------------------------------------------------------------------------
  assign upd_ctr = table_q[upd_idx];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != CTR_MIN) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = CTR_WEAK_NT;
    if (!ready) begin
      wr_en = 1'b1;
    end else if (upd_valid) begin
      wr_en   = 1'b1;
      wr_idx  = upd_idx;
      wr_data = upd_ctr_next;
    end
  end

  // NOTE: the table has no reset; the walker initialises it, keeping it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Global history: speculative shift at IF, repaired from the WB snapshot
  // ---------------------------------------------------------------------------
  if (HIST_BITS == 1) begin : g_hist_one
    assign ghr_shift   = pred_taken;
    assign ghr_recover = upd_taken;
  end else begin : g_hist_multi
    assign ghr_shift   = {ghr_q[HIST_BITS-2:0], pred_taken};
    assign ghr_recover = {upd_hist[HIST_BITS-2:0], upd_taken};
  end

  // A same-cycle lookup shift is discarded when WB repairs the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (recover) begin
      ghr_q <= ghr_recover;
    end else if (lookup_fire) begin
      ghr_q <= ghr_shift;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef PRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_fire) stat_lookups     <= stat_lookups + 32'd1;
      if (upd_fire)    stat_updates     <= stat_updates + 32'd1;
      if (recover)     stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_lookups     = '0;
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

  // Address bits outside the index field and the oldest carried history bit are not needed.
  if (IDX_BITS + 1 < ADDR_W) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^lookup_pc[ADDR_W-1:IDX_BITS+1];
  end
  logic unused_misc;
  assign unused_misc = ^{lookup_pc[0], upd_hist};

endmodule
